// File: rtl/mips_mem_arbiter_pkg.sv
// Shared types and constants for the Harvard-to-single-bus memory arbiter.
package mips_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DATA    = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  localparam logic [3:0] FETCH_BYTEENABLE = 4'hF;

endpackage

// File: rtl/mips_mem_arbiter.sv
// Serialises instruction fetch and data access of a Harvard MIPS core onto one
// Avalon-style bus, then gates the core forward by exactly one clock edge.
module mips_mem_arbiter
  import mips_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        cpu_active,
  output logic        cpu_clk_enable,
  input  logic [31:0] cpu_instr_address,
  output logic [31:0] cpu_instr_readdata,
  input  logic [31:0] cpu_data_address,
  input  logic        cpu_data_read,
  input  logic        cpu_data_write,
  input  logic [3:0]  cpu_byte_enable,
  input  logic [31:0] cpu_data_writedata,
  output logic [31:0] cpu_data_readdata,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic [31:0] stall_count,
  output logic        bus_error
);

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  arb_state_t  state_q, state_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic [31:0] instr_buf_q, instr_buf_d;
  logic [31:0] data_buf_q, data_buf_d;
  logic [31:0] stall_count_q;
  logic        bus_error_q, bus_error_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      instr_buf_q   <= '0;
      data_buf_q    <= '0;
      stall_count_q <= '0;
      bus_error_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      instr_buf_q <= instr_buf_d;
      data_buf_q  <= data_buf_d;
      bus_error_q <= bus_error_d;
      if (cpu_active && !cpu_clk_enable) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
    end
  end

  // Bus outputs decode from state and CPU inputs only; read data never feeds back.
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    instr_buf_d    = instr_buf_q;
    data_buf_d     = data_buf_q;
    bus_error_d    = bus_error_q;
    cpu_clk_enable = 1'b0;
    mem_address    = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_byteenable = '0;
    mem_writedata  = '0;

    case (state_q)
      IDLE: begin
        if (run && cpu_active && !bus_error_q) begin
          state_d    = FETCH;
          wait_cnt_d = '0;
        end
      end
      FETCH: begin
        mem_address    = cpu_instr_address;
        mem_read       = 1'b1;
        mem_byteenable = FETCH_BYTEENABLE;
        if (!mem_waitrequest) begin
          instr_buf_d = mem_readdata;
          wait_cnt_d  = '0;
          state_d     = (cpu_data_read || cpu_data_write) ? DATA : RELEASE;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          bus_error_d = 1'b1;
          state_d     = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
      DATA: begin
        // A simultaneous read request is dropped in favour of the write.
        mem_address    = cpu_data_address;
        mem_write      = cpu_data_write;
        mem_read       = !cpu_data_write;
        mem_byteenable = cpu_byte_enable;
        mem_writedata  = cpu_data_writedata;
        if (!mem_waitrequest) begin
          if (!cpu_data_write) begin
            data_buf_d = mem_readdata;
          end
          state_d = RELEASE;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          bus_error_d = 1'b1;
          state_d     = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
      RELEASE: begin
        cpu_clk_enable = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_instr_readdata = instr_buf_q;
  assign cpu_data_readdata  = data_buf_q;
  assign stall_count        = stall_count_q;
  assign bus_error          = bus_error_q;

endmodule

// File: doc/mips_mem_arbiter.md
# mips_mem_arbiter

Shares one Avalon-style single-port memory between the instruction and data ports of `mips_cpu_harvard`, turning it into a bus-based CPU. The arbiter owns the CPU's `clk_enable`. Each CPU step runs one instruction fetch, then at most one data access, on the shared bus. It then releases the CPU for exactly one clock edge with the fetched instruction and read data held stable. It sits between the CPU top level and the memory/bus wrapper.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: number of consecutive `mem_waitrequest` cycles on one transaction before `bus_error` is set.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `run` in 1: external run enable. Low means no new step is started.
- `cpu_active` in 1: CPU `active` output.
- `cpu_clk_enable` out 1: drives CPU `clk_enable`.
- `cpu_instr_address` in 32: fetch address from the CPU.
- `cpu_instr_readdata` out 32: held fetch word.
- `cpu_data_address` in 32: data address from the CPU.
- `cpu_data_read` in 1: data read request.
- `cpu_data_write` in 1: data write request.
- `cpu_byte_enable` in 4: byte lanes for the data access.
- `cpu_data_writedata` in 32: store data.
- `cpu_data_readdata` out 32: held load word.
- `mem_address` out 32: bus address.
- `mem_read` out 1: bus read strobe.
- `mem_write` out 1: bus write strobe.
- `mem_byteenable` out 4: bus byte lanes.
- `mem_writedata` out 32: bus write data.
- `mem_readdata` in 32: bus read data, valid in the completing cycle.
- `mem_waitrequest` in 1: bus stall.
- `stall_count` out 32: count of cycles with `cpu_clk_enable` low while `cpu_active`. Wraps at 2^32.
- `bus_error` out 1: sticky timeout flag.

## Operation
- State machine states: IDLE, FETCH, DATA, RELEASE.
- IDLE:
  - No bus strobes.
  - Go to FETCH when `run && cpu_active && !bus_error`.
- FETCH:
  - Drive `mem_address`=`cpu_instr_address`, `mem_read`=1, `mem_byteenable`=4'b1111.
  - A transfer completes in a cycle with a strobe high and `mem_waitrequest`=0.
  - On completion, latch `mem_readdata` into the instruction buffer.
  - Then go to DATA if `cpu_data_read|cpu_data_write`, otherwise to RELEASE.
- DATA:
  - Drive `cpu_data_address`, `cpu_byte_enable` and `cpu_data_writedata`.
  - Assert `mem_write` if `cpu_data_write`, else `mem_read`.
  - If both requests are high, the write wins and no read is issued.
  - On completion, latch read data (reads only) into the data buffer, then go to RELEASE.
- RELEASE:
  - `cpu_clk_enable`=1 for exactly this one cycle, then return to IDLE.
  - The CPU's inputs come only from the buffers, so CPU combinational changes during the step cannot disturb them.
- Each write is issued exactly once per step. Strobes drop in the cycle after completion.
- While `mem_waitrequest` is high, address, strobes, byte enables and write data are held constant.
- Timeout:
  - A per-transaction wait counter resets on entry to FETCH or DATA.
  - If it reaches `TIMEOUT_CYCLES`, set `bus_error`, drop the strobes and go to IDLE.
  - `bus_error` clears only on `reset`.
- When `cpu_active` falls (CPU halted at address 0), the arbiter finishes the current step and then parks in IDLE.

## Timing
- Reset values (asynchronous):
  - State = IDLE.
  - `cpu_clk_enable`, `mem_read`, `mem_write` = 0.
  - Both buffers, `stall_count`, the wait counter and `bus_error` = 0.
- `reset` mid-transaction aborts immediately; the bus strobes drop in the same cycle.
- The CPU gets its own reset on the same net. During reset the arbiter never pulses `cpu_clk_enable`; the CPU's internal `reset` OR handles that.
- Zero-wait latency per instruction:
  - 3 cycles with no data access (IDLE, FETCH, RELEASE).
  - 4 cycles with a data access.
  - Each wait-state cycle adds 1.
- Bus outputs are registered-state decodes: combinational from state and CPU inputs, with no path from `mem_readdata` to `mem_*`.
- `run` low blocks only the IDLE→FETCH transition. A step already in progress completes.

## Structure
- `mips_mem_arbiter_pkg` holds:
  - the `arb_state_t` enum (IDLE, FETCH, DATA, RELEASE);
  - `FETCH_BYTEENABLE` = 4'hF.
- Single module; no sub-module. The timeout and stall counters are inline.

## Test plan
- Zero-wait fetch only: instruction word 0x24020005 at 0xBFC00000 → `mem_read` for 1 cycle at 0xBFC00000, `cpu_clk_enable` pulses in cycle 3, `cpu_instr_readdata`=0x24020005.
- Load with 2 wait states: `cpu_data_read`=1, address 0x1000, memory returns 0xDEADBEEF → DATA lasts 3 cycles with address held, `cpu_data_readdata`=0xDEADBEEF at RELEASE, step takes 6 cycles.
- Store with `cpu_byte_enable`=4'b0011, data 0x0000ABCD → exactly one `mem_write` cycle with byteenable 0011, no `mem_read` in DATA.
- `cpu_data_read` and `cpu_data_write` both high → only `mem_write` issued.
- `mem_waitrequest` stuck high, `TIMEOUT_CYCLES`=8 → after 8 wait cycles `bus_error`=1, strobes low, no further `cpu_clk_enable` pulses.
- `reset` asserted in the middle of DATA → `mem_write`=0 in the same cycle, all outputs at reset values, and after release the first step fetches the new `cpu_instr_address`.
